// File: rtl/seq_mul_32.sv
// seq_mul_32: iterative 32x32 -> 64-bit unsigned shift-add multiplier.
// One 32-bit ripple-carry adder (carry-in 0) is reused over 32 iterations,
// one iteration per clock, instead of an array multiplier.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-high reset
//   start    in   1   request, sampled only while busy=0
//   a        in  32   multiplicand, latched on accepted start
//   b        in  32   multiplier, latched on accepted start
//   busy     out  1   high while iterating (CALC)
//   done     out  1   one-cycle pulse, product valid in that cycle
//   product  out 64   result, held until the next operation completes
//
// Parameter ZERO_BYPASS: a zero operand at start completes in one cycle.
module seq_mul_32 #(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 6;
  localparam int unsigned LAST = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    mq_q, mq_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2*W-1:0]  product_q, product_d;

  logic [W-1:0]    addend_c;
  logic [W-1:0]    sum_c;
  logic [W:0]      carry_c;

  // Ripple-carry adder: acc + (mq[0] ? mcand : 0), carry-in tied 0
  always_comb begin
    addend_c   = mq_q[0] ? mcand_q : '0;
    carry_c    = '0;
    sum_c      = '0;
    for (int i = 0; i < int'(W); i++) begin
      sum_c[i]       = acc_q[i] ^ addend_c[i] ^ carry_c[i];
      carry_c[i + 1] = (acc_q[i] & addend_c[i]) | (carry_c[i] & (acc_q[i] ^ addend_c[i]));
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start exactly like IDLE for back-to-back use
        state_d = IDLE;
        if (start) begin
          mcand_d = a;
          mq_d    = b;
          acc_d   = '0;
          count_d = '0;
          if (ZERO_BYPASS && ((a == '0) || (b == '0))) begin
            product_d = '0;
            state_d   = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Carry-out shifts into acc[31], so the 64-bit result is exact
        acc_d   = {carry_c[W], sum_c[W-1:1]};
        mq_d    = {sum_c[0], mq_q[W-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == CW'(LAST)) begin
          product_d = {acc_d, mq_d};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_mul_32.sv
// tb_seq_mul_32: scoreboard bench for seq_mul_32. Two instances run side by
// side, one with the zero bypass enabled and one without. Expected products,
// completion cycles and busy-cycle counts are queued at issue time and
// compared by independent monitors whenever done is seen.
module tb_seq_mul_32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start1 = 1'b0, start0 = 1'b0;
  logic [31:0] a1 = '0, b1 = '0, a0 = '0, b0 = '0;
  logic        busy1, done1, busy0, done0;
  logic [63:0] p1, p0;

  seq_mul_32 #(.ZERO_BYPASS(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .product(p1)
  );

  seq_mul_32 #(.ZERO_BYPASS(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .product(p0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int          due;
    int          nbusy;
  } exp_t;

  exp_t sb1[$];
  exp_t sb0[$];
  int   total = 0;
  int   bad   = 0;
  int   bc1   = 0;
  int   bc0   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for the bypass-enabled instance
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bc1 = 0;
    end else if (done1) begin
      if (sb1.size() == 0) begin
        chk("dut1 unexpected done", 64'(done1), 64'd0);
      end else begin
        e = sb1.pop_front();
        chk("dut1 product", p1, e.prod);
        chk("dut1 done cycle", 64'(cyc), 64'(e.due));
        chk("dut1 busy cycles", 64'(bc1), 64'(e.nbusy));
      end
      bc1 = 0;
    end else begin
      if (busy1) bc1++;
      if (sb1.size() > 0 && cyc > sb1[0].due) begin
        chk("dut1 done timeout", 64'(done1), 64'd1);
        void'(sb1.pop_front());
      end
    end
  end

  // Monitor for the no-bypass instance
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bc0 = 0;
    end else if (done0) begin
      if (sb0.size() == 0) begin
        chk("dut0 unexpected done", 64'(done0), 64'd0);
      end else begin
        e = sb0.pop_front();
        chk("dut0 product", p0, e.prod);
        chk("dut0 done cycle", 64'(cyc), 64'(e.due));
        chk("dut0 busy cycles", 64'(bc0), 64'(e.nbusy));
      end
      bc0 = 0;
    end else begin
      if (busy0) bc0++;
      if (sb0.size() > 0 && cyc > sb0[0].due) begin
        chk("dut0 done timeout", 64'(done0), 64'd1);
        void'(sb0.pop_front());
      end
    end
  end

  // Issue one operation on instance k (1: bypass, 0: no bypass); call at a negedge
  task automatic issue(input int k, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   g;
    g = 0;
    while ((k == 0 ? busy0 : busy1) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("issue wait for not busy", 64'(k == 0 ? busy0 : busy1), 64'd0);
    e.prod  = 64'(x) * 64'(y);
    e.nbusy = (k == 1 && (x == 32'd0 || y == 32'd0)) ? 0 : 32;
    e.due   = cyc + 1 + e.nbusy;
    if (k == 0) begin
      a0 = x; b0 = y; start0 = 1'b1;
      sb0.push_back(e);
    end else begin
      a1 = x; b1 = y; start1 = 1'b1;
      sb1.push_back(e);
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    // Scramble operands after acceptance; they must not matter any more
    if (k == 0) begin a0 = $urandom; b0 = $urandom; end
    else        begin a1 = $urandom; b1 = $urandom; end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb1.size() > 0 || sb0.size() > 0); i++) @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       pick = 32'd0;
      1:       pick = 32'hFFFF_FFFF;
      2:       pick = 32'(1) << $urandom_range(0, 31);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset busy1", 64'(busy1), 64'd0);
    chk("reset done1", 64'(done1), 64'd0);
    chk("reset product1", p1, 64'd0);
    chk("reset busy0", 64'(busy0), 64'd0);
    chk("reset done0", 64'(done0), 64'd0);
    chk("reset product0", p0, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(1, 32'd3, 32'd5);
    drain();
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    issue(1, 32'd0, 32'h1234_5678);
    drain();
    issue(0, 32'd0, 32'h1234_5678);
    drain();
    issue(1, 32'h1234_5678, 32'd0);
    drain();

    // Ignored start while busy, then back-to-back start in the done cycle
    issue(1, 32'd7, 32'd6);
    repeat (8) @(negedge clk);
    a1 = 32'd2; b1 = 32'd2; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 100 && !done1; i++) @(negedge clk);
    issue(1, 32'h0001_0000, 32'h0001_0000);
    drain();

    // Reset in the middle of an operation, between clock edges
    issue(1, 32'd9, 32'd9);
    repeat (13) @(negedge clk);
    #2 rst = 1'b1;
    sb1.delete();
    #1;
    chk("midop reset busy", 64'(busy1), 64'd0);
    chk("midop reset done", 64'(done1), 64'd0);
    chk("midop reset product", p1, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(1, 32'd9, 32'd9);
    drain();

    // Randomized streams; issue() waits only for busy to drop, so
    // consecutive operations start in the done cycle of the previous one
    for (int n = 0; n < 16; n++) begin
      issue(1, pick(), pick());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    for (int n = 0; n < 6; n++) issue(0, pick(), pick());
    drain();

    chk("dut1 scoreboard empty", 64'(sb1.size()), 64'd0);
    chk("dut0 scoreboard empty", 64'(sb0.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mul_32.md
Name: seq_mul_32

Overview:
- Iterative 32x32 -> 64-bit unsigned shift-add multiplier controller for the single-cycle CPU's MUL path.
- Sequences one instance of the existing combinational 32-bit ripple-carry adder (RCA_32_bit_comb, cin tied 0) over 32 iterations instead of building an array multiplier.
- Sits beside the ALU. The CPU stalls on busy and takes product on done.

Parameters:
- ZERO_BYPASS, 1: when 1, an operand of zero at start skips iteration and completes in one cycle with product 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only while busy=0.
- a  input  32  multiplicand. Latched on accepted start.
- b  input  32  multiplier. Latched on accepted start.
- busy  output  1  high while iterating (CALC state).
- done  output  1  one-cycle pulse. product is valid in that cycle.
- product  output  64  result. Holds until the next accepted start completes.

Behaviour:
- Reset, asynchronous, active-high, valid at any time including mid-operation:
  - state=IDLE, busy=0, done=0, product=0.
  - Internal acc, mq, mcand and count = 0.
  - The in-flight operation is discarded. No done is produced for it.
- States are IDLE, CALC and DONE.
- busy = (state==CALC). done = (state==DONE). Both are decoded directly from registered state.
- IDLE:
  - start=1 at an edge loads mcand<=a, mq<=b, acc<=0, count<=0.
  - If ZERO_BYPASS=1 and (a==0 or b==0), go to DONE with product<=0. Otherwise go to CALC.
  - start=0 stays in IDLE.
- CALC, one iteration per cycle:
  - Adder inputs are acc and (mq[0] ? mcand : 0). This gives {c,sum}.
  - Shift update: acc<={c,sum[31:1]}, mq<={sum[0],mq[31:1]}, count<=count+1.
  - count is 6 bits. On the edge where count==31, write product<={next acc,next mq} and go to DONE.
  - CALC therefore lasts exactly 32 cycles.
- DONE lasts exactly one cycle and behaves like IDLE for start:
  - start=1 is accepted and follows the same rules as IDLE.
  - start=0 goes to IDLE.
  - This allows back-to-back operations with no dead cycle.
- Latency, with start accepted at edge E0:
  - busy=1 in cycles E0..E31.
  - done=1 in the cycle after E32, with product valid.
  - Start-to-done is 33 edges. With the zero bypass it is 1 edge.
- start while busy=1 is ignored: no queuing, no effect on the running operation.
- Changing a and b after acceptance has no effect.
- Width rules:
  - Unsigned only.
  - The adder carry-out becomes bit 31 of the shifted acc, so no overflow is possible.
  - The full 64-bit product is exact.
- product changes only at the completing edge, at reset, or at a bypass completion. It never shows partial results.
- Simultaneous rst and start: rst wins.

Test Plan:
- Basic: reset, then start with a=3, b=5. Required: busy high 32 cycles, done pulse at edge 33, product=64'h0000_0000_0000_000F, done low the next cycle.
- Max operands: a=b=32'hFFFF_FFFF. Required: product=64'hFFFF_FFFE_0000_0001. Checks that the carry-out feeds acc.
- Zero bypass, ZERO_BYPASS=1: a=0, b=32'h1234_5678. Required: done the next cycle, product=0, busy never high.
- Same a=0, b=32'h1234_5678 with ZERO_BYPASS=0. Required: 33-cycle latency, product=0.
- Ignore and back-to-back: start a=7, b=6, then pulse start with a=2, b=2 at cycle 10 (ignored). Result must be 42. Assert start a=32'h0001_0000, b=32'h0001_0000 during the done cycle. Required: accepted immediately, product=64'h0000_0001_0000_0000 after 33 more edges.
- Reset mid-op: start a=9, b=9, assert rst asynchronously (between clock edges) at cycle 15. Required: busy, done and product drop to 0 immediately, no done pulse follows. A new start a=9, b=9 then yields product=81.
